multicycle_control: RTL and testbench
=====================================

# multicycle_control

Parametrised second-generation control FSM for the multi-cycle CPU. It sequences fetch, register load, ALU, memory load/store, register store and PC advance, like the first-generation controller. It adds four things: a memory request/ready handshake with wait states and a timeout, multi-cycle ALU support, single-step mode, and a sticky halt/fault report. It sits between the instruction decoder and the datapath, and its `do_*` strobes drive the register file, ALU, memory port and PC.

## Interface
- `OPCODE_SIZE`, 4: opcode width; opcode constants come from `parameters.vh`.
- `MEM_TIMEOUT`, 16: maximum wait cycles per memory access; 0 disables the timeout.
- `COUNT_WIDTH`, 32: width of the retired-instruction counter.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `execute`  in  1  run enable; when low, all state and counters freeze and all `do_*` strobes and `mem_req` are 0.
- `single_step`  in  1  when high, the FSM pauses after every instruction.
- `step_pulse`  in  1  one-cycle release from the pause.
- `opcode`  in  OPCODE_SIZE  decoded opcode of the current instruction.
- `is_alu_operation`  in  1  the current instruction is an ALU op.
- `alu_done`  in  1  ALU result valid; tie to 1 for single-cycle ALUs.
- `mem_ready`  in  1  memory has completed the current request.
- `mem_req`  out  1  memory request, high in FETCH/LOAD/STORE while `execute`.
- `do_fetch`, `do_reg_load`, `do_alu`, `do_mem_load`, `do_mem_store`, `do_reg_store`, `do_next`  out  1 each  datapath strobes.
- `do_reset`  out  1  `state==RESET` or `!reset_n`.
- `do_halt`  out  1  `state==HALT`.
- `halted`  out  1  sticky halt flag.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  2  00 none, 01 invalid opcode, 10 memory timeout.
- `instr_count`  out  COUNT_WIDTH  retired instructions; wraps modulo 2^COUNT_WIDTH.
- `state`  out  4  current state.

## Operation
- State encodings: RESET=0, FETCH=1, REGLOAD=2, ALU=3, LOAD=4, STORE=5, REGSTORE=6, NEXT=7, HALT=8, STEP_WAIT=9. These are added to `parameters.vh` as `STATE_*`.
- Reset (`reset_n` low): asynchronous. Sets `state`=RESET and clears `halted`, `fault`, `fault_code`, `instr_count` and the wait counter. `mem_req` and all `do_*` strobes except `do_reset` are 0.
- No transition occurs on a clock edge with `execute`=0.

Transitions, each on an edge with `execute`=1:
- RESET→FETCH.
- FETCH→REGLOAD when `mem_ready`=1; otherwise stay.
- REGLOAD dispatch. `is_alu_operation` has priority and goes to ALU. Otherwise:
  - `LOAD`→LOAD
  - `STORE`→STORE
  - `LUI`/`LI`→REGSTORE
  - `BEQ`/`BNE`→NEXT
  - `HALT`→HALT
  - any other opcode→HALT with `fault`=1 and `fault_code`=01.
- ALU→REGSTORE when `alu_done`=1; otherwise stay.
- LOAD→REGSTORE when `mem_ready`=1.
- STORE→NEXT when `mem_ready`=1.
- REGSTORE→NEXT.
- NEXT→STEP_WAIT if `single_step`=1, else FETCH. `instr_count` increments on this edge.
- STEP_WAIT→FETCH when `step_pulse`=1. `step_pulse` is ignored in every other state.
- If `single_step` drops while in STEP_WAIT, the FSM leaves to FETCH on the next edge.
- HALT→HALT until reset; `halted`=1.

Strobes (Moore plus handshake):
- `do_fetch`, `do_mem_load` and `do_mem_store` are each high only in the single cycle where their state matches and `execute` && `mem_ready` are true. The datapath captures on that cycle.
- `do_alu` = (state==ALU) && `execute`. It stays high for every cycle of a multi-cycle op.
- `do_reg_load`, `do_reg_store`, `do_next` = state match && `execute`.

Memory timeout:
- The wait counter clears on entry to FETCH, LOAD or STORE.
- It increments on each edge in one of those states with `execute`=1 and `mem_ready`=0.
- When it reaches MEM_TIMEOUT (and MEM_TIMEOUT≠0), the FSM goes to HALT with `fault`=1 and `fault_code`=10.
- A `mem_ready` arriving on that same edge wins: the access completes and no fault is raised.

## Timing
- Minimum latency per instruction, with ready/done tied high:
  - ALU op: 5 cycles (FETCH, REGLOAD, ALU, REGSTORE, NEXT).
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - LUI/LI: 4 cycles.
  - Branch: 3 cycles.
- One extra cycle is added per memory wait cycle or per `alu_done`-low cycle.
- `reset_n` is asserted asynchronously: `state`, `mem_req` and the strobes go to their reset values without waiting for a clock edge. Release is synchronous in effect, because the first transition happens on the first edge after release.
- `halted`/`fault` set on the same edge that enters HALT.

## Test plan
- Pulse `reset_n` low, then hold `execute`=1, `mem_ready`=1, `alu_done`=1, `is_alu_operation`=1. Required: `state` sequence 0,1,2,3,6,7,1 and `instr_count`=1 after the NEXT edge.
- Run a LOAD with `mem_ready` delayed by 3 cycles. Required: `mem_req` high for 4 cycles in state 4, `do_mem_load` high only in the 4th cycle, then state 6, 7.
- Set MEM_TIMEOUT=4 and hold `mem_ready`=0 in FETCH. Required: HALT after 4 wait edges, `fault`=1, `fault_code`=10, `halted` held until `reset_n` is asserted.
- Drive an undefined opcode at REGLOAD. Required: HALT, `fault_code`=01. Separately, drive the `HALT` opcode. Required: HALT with `fault`=0.
- Drop `execute` for 3 cycles in ALU with `alu_done`=0. Required: `state` stays 3 and `do_alu`=0 throughout. With `single_step`=1, the FSM sits in state 9 until `step_pulse`, then enters FETCH.
- Assert `reset_n` low mid-wait in STORE. Required: `state`=0, `mem_req`=0, `instr_count`=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle CPU controller and its decoder/datapath.
interface multicycle_control_if #(
   parameter int OPCODE_SIZE = 4,
   parameter int COUNT_WIDTH = 32
);
   logic                   execute;
   logic                   single_step;
   logic                   step_pulse;
   logic [OPCODE_SIZE-1:0] opcode;
   logic                   is_alu_operation;
   logic                   alu_done;
   logic                   mem_ready;
   logic                   mem_req;
   logic                   do_fetch;
   logic                   do_reg_load;
   logic                   do_alu;
   logic                   do_mem_load;
   logic                   do_mem_store;
   logic                   do_reg_store;
   logic                   do_next;
   logic                   do_reset;
   logic                   do_halt;
   logic                   halted;
   logic                   fault;
   logic [1:0]             fault_code;
   logic [COUNT_WIDTH-1:0] instr_count;
   logic [3:0]             state;

   modport master (
      input  execute, single_step, step_pulse, opcode, is_alu_operation, alu_done, mem_ready,
      output mem_req, do_fetch, do_reg_load, do_alu, do_mem_load, do_mem_store, do_reg_store,
             do_next, do_reset, do_halt, halted, fault, fault_code, instr_count, state
   );

   modport slave (
      output execute, single_step, step_pulse, opcode, is_alu_operation, alu_done, mem_ready,
      input  mem_req, do_fetch, do_reg_load, do_alu, do_mem_load, do_mem_store, do_reg_store,
             do_next, do_reset, do_halt, halted, fault, fault_code, instr_count, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Second-generation multi-cycle CPU control FSM: memory handshake with timeout,
// multi-cycle ALU, single-step pause and sticky halt/fault reporting.
module multicycle_control #(
   parameter int                     OPCODE_SIZE = 4,
   parameter int                     MEM_TIMEOUT = 16,
   parameter int                     COUNT_WIDTH = 32,
   parameter logic [OPCODE_SIZE-1:0] OP_LOAD     = OPCODE_SIZE'(8),
   parameter logic [OPCODE_SIZE-1:0] OP_STORE    = OPCODE_SIZE'(9),
   parameter logic [OPCODE_SIZE-1:0] OP_LUI      = OPCODE_SIZE'(10),
   parameter logic [OPCODE_SIZE-1:0] OP_LI       = OPCODE_SIZE'(11),
   parameter logic [OPCODE_SIZE-1:0] OP_BEQ      = OPCODE_SIZE'(12),
   parameter logic [OPCODE_SIZE-1:0] OP_BNE      = OPCODE_SIZE'(13),
   parameter logic [OPCODE_SIZE-1:0] OP_HALT     = OPCODE_SIZE'(15)
) (
   input logic                  clock,
   input logic                  reset_n,
   multicycle_control_if.master bus
);
   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_FETCH     = 4'd1,
      S_REGLOAD   = 4'd2,
      S_ALU       = 4'd3,
      S_LOAD      = 4'd4,
      S_STORE     = 4'd5,
      S_REGSTORE  = 4'd6,
      S_NEXT      = 4'd7,
      S_HALT      = 4'd8,
      S_STEP_WAIT = 4'd9
   } state_t;

   localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 2);
   localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT_EN ? MEM_TIMEOUT - 1 : 0);

   state_t                 state_q, state_d;
   logic [WAIT_W-1:0]      wait_q, wait_d;
   logic                   halted_q, halted_d;
   logic                   fault_q, fault_d;
   logic [1:0]             code_q, code_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   mem_state;
   logic                   timed_out;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_RESET;
         wait_q   <= '0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
         code_q   <= 2'b00;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
         code_q   <= code_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      halted_d  = halted_q;
      fault_d   = fault_q;
      code_d    = code_q;
      count_d   = count_q;
      mem_state = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_STORE);
      // A ready arriving on the last allowed wait edge completes the access instead.
      timed_out = TIMEOUT_EN && mem_state && !bus.mem_ready && (wait_q == WAIT_LAST);
      if (bus.execute) begin
         case (state_q)
            S_RESET:    state_d = S_FETCH;
            S_FETCH:    if (bus.mem_ready) state_d = S_REGLOAD;
            S_REGLOAD: begin
               if (bus.is_alu_operation)                            state_d = S_ALU;
               else if (bus.opcode == OP_LOAD)                      state_d = S_LOAD;
               else if (bus.opcode == OP_STORE)                     state_d = S_STORE;
               else if (bus.opcode == OP_LUI || bus.opcode == OP_LI)  state_d = S_REGSTORE;
               else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE) state_d = S_NEXT;
               else if (bus.opcode == OP_HALT)                      state_d = S_HALT;
               else begin
                  state_d = S_HALT;
                  fault_d = 1'b1;
                  code_d  = 2'b01;
               end
            end
            S_ALU:       if (bus.alu_done) state_d = S_REGSTORE;
            S_LOAD:      if (bus.mem_ready) state_d = S_REGSTORE;
            S_STORE:     if (bus.mem_ready) state_d = S_NEXT;
            S_REGSTORE:  state_d = S_NEXT;
            S_NEXT: begin
               state_d = bus.single_step ? S_STEP_WAIT : S_FETCH;
               count_d = count_q + COUNT_WIDTH'(1);
            end
            S_STEP_WAIT: if (bus.step_pulse || !bus.single_step) state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_RESET;
         endcase
         if (timed_out) begin
            state_d = S_HALT;
            fault_d = 1'b1;
            code_d  = 2'b10;
         end
         if (state_d == S_HALT) halted_d = 1'b1;
         // Any state change clears the counter, so each memory access starts from zero.
         if (state_d != state_q) wait_d = '0;
         else if (mem_state && !bus.mem_ready) wait_d = wait_q + WAIT_W'(1);
      end
   end

   assign bus.mem_req      = bus.execute && mem_state;
   assign bus.do_fetch     = bus.execute && bus.mem_ready && (state_q == S_FETCH);
   assign bus.do_mem_load  = bus.execute && bus.mem_ready && (state_q == S_LOAD);
   assign bus.do_mem_store = bus.execute && bus.mem_ready && (state_q == S_STORE);
   assign bus.do_reg_load  = bus.execute && (state_q == S_REGLOAD);
   assign bus.do_alu       = bus.execute && (state_q == S_ALU);
   assign bus.do_reg_store = bus.execute && (state_q == S_REGSTORE);
   assign bus.do_next      = bus.execute && (state_q == S_NEXT);
   assign bus.do_reset     = (state_q == S_RESET) || !reset_n;
   assign bus.do_halt      = (state_q == S_HALT);
   assign bus.halted       = halted_q;
   assign bus.fault        = fault_q;
   assign bus.fault_code   = code_q;
   assign bus.instr_count  = count_q;
   assign bus.state        = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: expected per-cycle state/strobe trace is built
// from instruction classes and wait counts, then replayed against the DUT.
module tb_multicycle_control;
   localparam int CW = 3;
   localparam logic [3:0] OP_LOAD = 4'd8, OP_STORE = 4'd9, OP_LUI = 4'd10, OP_LI = 4'd11;
   localparam logic [3:0] OP_BEQ = 4'd12, OP_BNE = 4'd13, OP_HALT = 4'd15, OP_UNDEF = 4'd14;
   localparam logic [3:0] ST_RESET = 4'd0, ST_FETCH = 4'd1, ST_REGLOAD = 4'd2, ST_ALU = 4'd3;
   localparam logic [3:0] ST_LOAD = 4'd4, ST_STORE = 4'd5, ST_REGSTORE = 4'd6, ST_NEXT = 4'd7;
   localparam logic [3:0] ST_HALT = 4'd8, ST_STEP_WAIT = 4'd9;
   localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_IMM = 3, K_BR = 4;

   typedef struct {
      logic [3:0]  st;
      bit          ex, rdy, done, ss, sp, alu;
      logic [3:0]  op;
      int unsigned cnt;
   } cyc_t;

   logic clock;
   logic reset_n;
   multicycle_control_if #(.OPCODE_SIZE(4), .COUNT_WIDTH(CW)) bus ();

   multicycle_control #(
      .OPCODE_SIZE(4), .MEM_TIMEOUT(4), .COUNT_WIDTH(CW),
      .OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE), .OP_LUI(OP_LUI), .OP_LI(OP_LI),
      .OP_BEQ(OP_BEQ), .OP_BNE(OP_BNE), .OP_HALT(OP_HALT)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_err = 0;
   cyc_t        q[$];
   int unsigned model_count;
   bit          cur_ss, cur_alu, freeze_en;
   logic [3:0]  cur_op;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   function automatic logic [9:0] exp_strobes(input cyc_t e);
      logic m;
      m = (e.st == ST_FETCH) || (e.st == ST_LOAD) || (e.st == ST_STORE);
      return {e.st == ST_RESET, e.st == ST_HALT, e.ex && m,
              e.ex && e.rdy && e.st == ST_FETCH, e.ex && e.st == ST_REGLOAD,
              e.ex && e.st == ST_ALU, e.ex && e.rdy && e.st == ST_LOAD,
              e.ex && e.rdy && e.st == ST_STORE, e.ex && e.st == ST_REGSTORE,
              e.ex && e.st == ST_NEXT};
   endfunction

   function automatic logic [9:0] obs_strobes();
      return {bus.do_reset, bus.do_halt, bus.mem_req, bus.do_fetch, bus.do_reg_load,
              bus.do_alu, bus.do_mem_load, bus.do_mem_store, bus.do_reg_store, bus.do_next};
   endfunction

   task automatic push_raw(input logic [3:0] st, input bit ex, input bit rdy, input bit done,
                           input bit sp);
      cyc_t e;
      e.st = st; e.ex = ex; e.rdy = rdy; e.done = done; e.ss = cur_ss; e.sp = sp;
      e.alu = cur_alu; e.op = cur_op; e.cnt = model_count;
      q.push_back(e);
   endtask

   // Optionally precede a cycle with a frozen (execute=0) copy carrying random inputs.
   task automatic push_cycle(input logic [3:0] st, input bit rdy, input bit done);
      if (freeze_en && $urandom_range(0, 5) == 0) push_raw(st, 1'b0, rb(), rb(), rb());
      push_raw(st, 1'b1, rdy, done, rb());
   endtask

   // sw >= 0: STEP_WAIT cycles before the pulse; sw < 0: single_step drops instead.
   task automatic push_instr(input int kind, input int fw, input int xw, input bit ss,
                             input int sw);
      cur_ss  = rb();
      cur_alu = (kind == K_ALU);
      case (kind)
         K_ALU:   cur_op = 4'($urandom_range(0, 15));
         K_LOAD:  cur_op = OP_LOAD;
         K_STORE: cur_op = OP_STORE;
         K_IMM:   cur_op = rb() ? OP_LUI : OP_LI;
         default: cur_op = rb() ? OP_BEQ : OP_BNE;
      endcase
      for (int i = 0; i <= fw; i++) push_cycle(ST_FETCH, i == fw, rb());
      push_cycle(ST_REGLOAD, rb(), rb());
      if (kind == K_ALU)   for (int i = 0; i <= xw; i++) push_cycle(ST_ALU, rb(), i == xw);
      if (kind == K_LOAD)  for (int i = 0; i <= xw; i++) push_cycle(ST_LOAD, i == xw, rb());
      if (kind == K_STORE) for (int i = 0; i <= xw; i++) push_cycle(ST_STORE, i == xw, rb());
      if (kind == K_ALU || kind == K_LOAD || kind == K_IMM) push_cycle(ST_REGSTORE, rb(), rb());
      cur_ss = ss;
      push_cycle(ST_NEXT, rb(), rb());
      model_count++;
      if (ss) begin
         if (sw < 0) begin
            cur_ss = 1'b0;
            push_raw(ST_STEP_WAIT, 1'b1, rb(), rb(), 1'b0);
         end else begin
            repeat (sw) push_raw(ST_STEP_WAIT, 1'b1, rb(), rb(), 1'b0);
            push_raw(ST_STEP_WAIT, 1'b1, rb(), rb(), 1'b1);
         end
      end
      cur_ss = 1'b0;
   endtask

   task automatic run_queue();
      cyc_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         bus.execute = e.ex; bus.mem_ready = e.rdy; bus.alu_done = e.done;
         bus.single_step = e.ss; bus.step_pulse = e.sp;
         bus.opcode = e.op; bus.is_alu_operation = e.alu;
         @(negedge clock);
         chk("state", 32'(bus.state), 32'(e.st));
         chk("strobes", 32'(obs_strobes()), 32'(exp_strobes(e)));
         chk("instr_count", 32'(bus.instr_count), e.cnt % (1 << CW));
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset_seq();
      bus.execute = 1'b0; bus.mem_ready = 1'b0; bus.alu_done = 1'b0; bus.single_step = 1'b0;
      bus.step_pulse = 1'b0; bus.opcode = 4'd0; bus.is_alu_operation = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("rst_state", 32'(bus.state), 32'(ST_RESET));
      chk("rst_strobes", 32'(obs_strobes()), 32'h200);
      chk("rst_flags", {bus.halted, bus.fault, bus.fault_code, 28'(bus.instr_count)}, 32'h0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      model_count = 0; cur_ss = 1'b0; cur_alu = 1'b0; cur_op = 4'd0; freeze_en = 1'b0;
      q.delete();
      push_raw(ST_RESET, 1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      reset_n = 1'b1;
      #2;
      // Basic ALU instruction: 0,1,2,3,6,7,1.
      do_reset_seq();
      push_instr(K_ALU, 0, 0, 1'b0, 0);
      push_raw(ST_FETCH, 1'b1, 1'b0, 1'b1, 1'b0);
      run_queue();
      chk("count_after_next", 32'(bus.instr_count), 32'd1);

      // LOAD with three wait cycles, then a STORE that also rides the timeout edge.
      do_reset_seq();
      push_instr(K_LOAD, 0, 3, 1'b0, 0);
      push_instr(K_STORE, 3, 3, 1'b0, 0);
      run_queue();

      // Fetch timeout.
      do_reset_seq();
      repeat (4) push_raw(ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) push_raw(ST_HALT, 1'b1, rb(), rb(), rb());
      run_queue();
      chk("timeout_flags", {bus.halted, bus.fault, bus.fault_code}, 32'b1110);
      reset_n = 1'b0;
      #1;
      chk("timeout_cleared", {bus.halted, bus.fault, bus.fault_code}, 32'b0000);

      // Undefined opcode, then the HALT opcode.
      do_reset_seq();
      cur_op = OP_UNDEF;
      push_raw(ST_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
      push_raw(ST_REGLOAD, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) push_raw(ST_HALT, 1'b1, rb(), rb(), 1'b0);
      run_queue();
      chk("undef_flags", {bus.halted, bus.fault, bus.fault_code}, 32'b1101);
      do_reset_seq();
      cur_op = OP_HALT;
      push_raw(ST_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
      push_raw(ST_REGLOAD, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) push_raw(ST_HALT, 1'b1, rb(), rb(), 1'b0);
      run_queue();
      chk("halt_flags", {bus.halted, bus.fault, bus.fault_code}, 32'b1000);

      // Execute dropped mid multi-cycle ALU, then single-step pause and release.
      do_reset_seq();
      cur_alu = 1'b1; cur_op = 4'd3;
      push_raw(ST_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
      push_raw(ST_REGLOAD, 1'b1, 1'b0, 1'b0, 1'b0);
      push_raw(ST_ALU, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) push_raw(ST_ALU, 1'b0, rb(), 1'b0, rb());
      push_raw(ST_ALU, 1'b1, 1'b0, 1'b1, 1'b0);
      push_raw(ST_REGSTORE, 1'b1, 1'b0, 1'b0, 1'b0);
      cur_ss = 1'b1;
      push_raw(ST_NEXT, 1'b1, 1'b0, 1'b0, 1'b0);
      model_count++;
      repeat (3) push_raw(ST_STEP_WAIT, 1'b1, rb(), rb(), 1'b0);
      push_raw(ST_STEP_WAIT, 1'b1, 1'b0, 1'b0, 1'b1);
      push_instr(K_BR, 0, 0, 1'b1, -1);
      push_raw(ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
      run_queue();

      // Asynchronous reset mid-wait in STORE.
      do_reset_seq();
      push_instr(K_BR, 0, 0, 1'b0, 0);
      cur_op = OP_STORE;
      push_raw(ST_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
      push_raw(ST_REGLOAD, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) push_raw(ST_STORE, 1'b1, 1'b0, 1'b0, 1'b0);
      run_queue();
      reset_n = 1'b0;
      #1;
      chk("async_state", 32'(bus.state), 32'(ST_RESET));
      chk("async_mem_req", 32'(bus.mem_req), 32'd0);
      chk("async_count", 32'(bus.instr_count), 32'd0);
      chk("async_do_reset", 32'(bus.do_reset), 32'd1);

      // Randomized program with frozen cycles, single-step pauses and counter wrap.
      do_reset_seq();
      freeze_en = 1'b1;
      for (int n = 0; n < 40; n++)
         push_instr($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2));
      run_queue();
      chk("random_final_count", 32'(bus.instr_count), 32'(40 % (1 << CW)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
